cpu_seq_ctrl: RTL
=================

# cpu_seq_ctrl

Multi-cycle sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and write-back, using the decode signals produced by the control generator. It owns the instruction- and data-memory request handshakes, gates the PC, instruction-register and register-file write enables, and traps on illegal opcodes or memory time-outs. It also keeps the retired-instruction and cycle counters.

## Interface
Parameters:
- CNT_W, 32, width of instret/cycles counters
- TIMEOUT, 255, max cycles a memory request may wait for ack before trap (1..2^16-1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; **synchronous, active-high**; the block uses this single clock only
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- dmem_ack  in  1  data access complete this cycle
- dec_op  in  5  instr[6:2]
- dec_regwr  in  1  decoded register write
- dec_memtoreg  in  1  decoded load
- dec_memwr  in  1  decoded store
- ir_we  out  1  load instruction register (1-cycle pulse)
- pc_we  out  1  commit next PC (1-cycle pulse)
- rf_we  out  1  register-file write (1-cycle pulse)
- trap  out  1  sticky fault flag
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
- state  out  3  current state encoding, for debug
- instret  out  CNT_W  retired instruction count
- cycles  out  CNT_W  non-trap cycle count

## Operation
State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.

- **Outputs**
  - All outputs are decoded from registered state.
  - imem_req=(FETCH), dmem_req=(MEM), dmem_we=(MEM & dec_memwr).
  - While rst=1, every request and write-enable output is forced to 0.
- **FETCH:** hold imem_req until imem_ack; on ack pulse ir_we and go to DECODE.
- **DECODE**
  - Legal dec_op set: 01101, 00101, 11011, 11001, 11000, 00000, 01000, 00100, 01100.
  - Illegal opcode → TRAP with cause 1; otherwise → EXEC.
- **EXEC**
  - Load (dec_memtoreg) or store (dec_memwr) → MEM.
  - Else if dec_regwr → WB.
  - Else (branch) pulse pc_we, increment instret, → FETCH.
- **MEM**
  - Hold dmem_req until dmem_ack.
  - On ack: a store pulses pc_we, increments instret and → FETCH; a load → WB.
- **WB:** pulse rf_we and pc_we, increment instret, → FETCH.
- **TRAP**
  - Absorbing; all requests and enables are 0; trap=1.
  - Only rst leaves TRAP.
- **Watchdog**
  - Clears on every state entry.
  - Counts each cycle in FETCH/MEM without ack.
  - Reaching TIMEOUT → TRAP with cause 2 (FETCH) or 3 (MEM).
- **Ack handling**
  - Ack and timeout in the same cycle: ack wins.
  - imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- **Counters**
  - cycles increments every cycle state≠TRAP; instret increments per retirement.
  - Both wrap modulo 2^CNT_W.
- **dec_* sampling:** dec_* inputs are sampled only in DECODE/EXEC/MEM. Upstream holds them stable from ir_we until the next ir_we.

## Timing
- **Reset values:** state=FETCH, instret=0, cycles=0, trap=0, trap_cause=0, all pulses 0. imem_req rises in the first cycle after rst falls.
- **Latency with zero-wait ack:** ALU/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3. Each wait cycle adds 1.
- **Pulse widths:** ir_we, pc_we and rf_we are exactly 1 cycle wide. pc_we and rf_we coincide in WB.
- **Request hold:** requests stay high continuously until ack; they drop the cycle after ack.
- **Reset mid-operation:** rst in any state, including MEM with a request outstanding, returns to FETCH on the next edge. A dmem_ack arriving during rst is dropped.
- **trap_cause:** latched at trap entry; unchanged until reset.

## Structure
- **Package cpu_seq_pkg:**
  - state encodings;
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP;
  - trap-cause constants.
- **Sub-module seq_wdog:** a clearable saturating counter with a TIMEOUT compare, used by the watchdog.

## Test plan
- **ADDI (dec_op=00100, dec_regwr=1), acks immediate:** ir_we at cycle 1, rf_we+pc_we at cycle 3, instret=1 after 4 cycles.
- **Load with dmem_ack delayed 3 cycles:** dmem_req high 4 cycles, dmem_we=0, rf_we 1 cycle after ack, total 8 cycles.
- **Store (dec_memwr=1):** dmem_we=1 with dmem_req, pc_we on ack cycle+1, rf_we never asserts.
- **dec_op=11111:** TRAP after DECODE, trap=1, trap_cause=1, cycles frozen, further acks ignored.
- **imem_ack withheld, TIMEOUT=4:** trap_cause=2 after 4 waiting cycles; a second run with ack on the 4th cycle shows ack wins and no trap.
- **Reset mid-MEM:** assert rst with dmem_req high. Next cycle dmem_req=0, state=FETCH, counters 0; instret=2^CNT_W-1 then one retire wraps to 0 (CNT_W=4 build).

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state encodings,
// major-opcode constants (instr[6:2]) and trap-cause codes.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  // True for the nine major opcodes this core executes.
  function automatic logic is_legal_op(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_wdog.sv
// Memory-wait watchdog: a clearable, saturating 16-bit cycle counter.
// expire fires in the cycle where one more un-acked wait would reach TIMEOUT.
import cpu_seq_pkg::*;

module seq_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;

  // Count waiting cycles; clear on reset or whenever the owner changes state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expire = inc && (cnt_q >= LIMIT);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Owns the imem/dmem request handshakes, the ir/pc/rf write-enable pulses,
// trap detection and the instret/cycles counters.
//
// Handshake: a request (imem_req in FETCH, dmem_req in MEM) is held high
// every cycle until the matching ack is seen in the same cycle; the request
// drops the cycle after the ack. Acks seen while no request is up are ignored.
import cpu_seq_pkg::*;

module cpu_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic [4:0]       dec_op,
  input  logic             dec_regwr,
  input  logic             dec_memtoreg,
  input  logic             dec_memwr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  state_t           state_q, state_d;
  logic             retire;
  logic [1:0]       cause_d;
  logic [1:0]       cause_q;
  logic             ir_we_q, pc_we_q, rf_we_q;
  logic [CNT_W-1:0] instret_q, cycles_q;
  logic             wdog_inc, wdog_clr, wdog_expire;

  // Waits are counted only while a request is outstanding and unanswered.
  assign wdog_inc = ((state_q == ST_FETCH) && !imem_ack) ||
                    ((state_q == ST_MEM)   && !dmem_ack);
  assign wdog_clr = (state_d != state_q);

  seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdog_clr),
    .inc    (wdog_inc),
    .expire (wdog_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack always beats a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    cause_d = CAUSE_NONE;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (wdog_expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal_op(dec_op)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (dec_memtoreg || dec_memwr) begin
          state_d = ST_MEM;
        end else if (dec_regwr) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (dec_memwr) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wdog_expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // One-cycle write-enable pulses, registered from the transition that
  // causes them: ir_we lands in DECODE, rf_we/pc_we together in WB, and the
  // pc_we of a branch or store lands in the following FETCH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_we_q <= 1'b0;
      pc_we_q <= 1'b0;
      rf_we_q <= 1'b0;
    end else begin
      ir_we_q <= (state_q == ST_FETCH) && imem_ack;
      rf_we_q <= (state_d == ST_WB);
      pc_we_q <= (state_d == ST_WB) || (retire && (state_q != ST_WB));
    end
  end

  // Trap cause is captured once on entry and held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= CAUSE_NONE;
    end else if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
      cause_q <= cause_d;
    end
  end

  // Performance counters, both free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (state_q != ST_TRAP) begin
        cycles_q <= cycles_q + CNT_W'(1);
      end
    end
  end

  assign imem_req   = (state_q == ST_FETCH) && !rst;
  assign dmem_req   = (state_q == ST_MEM) && !rst;
  assign dmem_we    = (state_q == ST_MEM) && dec_memwr && !rst;
  assign ir_we      = ir_we_q && !rst;
  assign pc_we      = pc_we_q && !rst;
  assign rf_we      = rf_we_q && !rst;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;
  assign cycles     = cycles_q;

endmodule
